// File: rtl/sparse_matrix_pkg.sv
// sparse_matrix_pkg: shared sizing, the coordinate-entry struct, the
// power-on matrix contents and the scanner state encoding.
package sparse_matrix_pkg;

  localparam int N_ENTRIES = 15;
  localparam int W         = 16;
  localparam int IDX_W     = 4;

  typedef struct packed {
    logic [W-1:0] row;
    logic [W-1:0] col;
    logic [W-1:0] data;
  } entry_t;

  typedef entry_t [N_ENTRIES-1:0] matrix_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_e;

  function automatic entry_t ent(input int r, input int c, input int d);
    entry_t e;
    e.row  = W'(r);
    e.col  = W'(c);
    e.data = W'(d);
    return e;
  endfunction

  // Highest slot first so that DEFAULT_MATRIX[k] is slot k.
  localparam matrix_t DEFAULT_MATRIX = {
    ent(7, 7, 15), ent(6, 6, 14), ent(6, 2, 13), ent(5, 5, 12), ent(5, 1, 11),
    ent(4, 4, 10), ent(4, 0,  9), ent(3, 3,  8), ent(3, 1,  7), ent(2, 2,  6),
    ent(2, 0,  5), ent(1, 3,  4), ent(1, 1,  3), ent(0, 2,  2), ent(0, 0,  1)
  };

endpackage

// File: rtl/coo_scanner.sv
// coo_scanner: walks all storage slots in ascending order, one per clock,
// and emits every slot whose row (select=0) or column (select=1) equals
// the number latched at start.
//   clk, rst          : clock, async active-low reset
//   start             : begin a scan (only honoured in IDLE)
//   row_col_select    : 0 = match rows, 1 = match columns
//   row_col_number    : value to match
//   tree_row/col/data : storage contents, read combinationally
//   busy              : scan in progress (SCAN or DONE)
//   out_valid         : row/col/value carry a matching slot this cycle
//   row/col/value     : last matching slot (held when out_valid=0)
//   done              : one-cycle pulse after the scan finishes
module coo_scanner
  import sparse_matrix_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          row_col_select,
  input  logic [W-1:0]                  row_col_number,
  input  logic [N_ENTRIES-1:0][W-1:0]   tree_row,
  input  logic [N_ENTRIES-1:0][W-1:0]   tree_col,
  input  logic [N_ENTRIES-1:0][W-1:0]   tree_data,
  output logic                          busy,
  output logic                          out_valid,
  output logic [W-1:0]                  row,
  output logic [W-1:0]                  col,
  output logic [W-1:0]                  value,
  output logic                          done
);

  scan_state_e      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             sel_q, sel_d;
  logic [W-1:0]     num_q, num_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     row_q, row_d, col_q, col_d, value_q, value_d;
  logic             done_q, done_d;
  logic [W-1:0]     key;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    sel_d       = sel_q;
    num_d       = num_q;
    out_valid_d = 1'b0;
    row_d       = row_q;
    col_d       = col_q;
    value_d     = value_q;
    done_d      = 1'b0;
    key         = sel_q ? tree_col[idx_q] : tree_row[idx_q];
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sel_d   = row_col_select;
          num_d   = row_col_number;
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        // Storage is read before any same-edge write lands, so a slot
        // rewritten in its own compare cycle is judged on old contents.
        if (key == num_q) begin
          out_valid_d = 1'b1;
          row_d       = tree_row[idx_q];
          col_d       = tree_col[idx_q];
          value_d     = tree_data[idx_q];
        end
        if (idx_q == IDX_W'(N_ENTRIES - 1)) state_d = DONE;
        else                                 idx_d   = idx_q + IDX_W'(1);
      end
      DONE: begin
        // done is registered so it lands one cycle after the DONE state,
        // i.e. 16 edges after the start edge.
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      sel_q       <= 1'b0;
      num_q       <= '0;
      out_valid_q <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      value_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sel_q       <= sel_d;
      num_q       <= num_d;
      out_valid_q <= out_valid_d;
      row_q       <= row_d;
      col_q       <= col_d;
      value_q     <= value_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign row       = row_q;
  assign col       = col_q;
  assign value     = value_q;
  assign done      = done_q;

endmodule

// File: rtl/sparse_matrix_tree.sv
// sparse_matrix_tree: 15-slot coordinate-form sparse matrix store with a
// write port and a row/column scanner streaming matching (row,col,value).
//   clk, rst                  : clock, async active-low reset
//   wr_en, wr_idx             : write slot wr_idx (15 is ignored)
//   wr_row/wr_col/wr_data     : entry written
//   start, row_col_select,
//   row_col_number            : scan request
//   busy, out_valid, row, col,
//   value, done               : scan results
module sparse_matrix_tree
  import sparse_matrix_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [W-1:0]     wr_row,
  input  logic [W-1:0]     wr_col,
  input  logic [W-1:0]     wr_data,
  input  logic             start,
  input  logic             row_col_select,
  input  logic [W-1:0]     row_col_number,
  output logic             busy,
  output logic             out_valid,
  output logic [W-1:0]     row,
  output logic [W-1:0]     col,
  output logic [W-1:0]     value,
  output logic             done
);

  logic [N_ENTRIES-1:0][W-1:0] tree_row_q, tree_row_d;
  logic [N_ENTRIES-1:0][W-1:0] tree_col_q, tree_col_d;
  logic [N_ENTRIES-1:0][W-1:0] tree_data_q, tree_data_d;

  always_comb begin
    tree_row_d  = tree_row_q;
    tree_col_d  = tree_col_q;
    tree_data_d = tree_data_q;
    if (wr_en && (wr_idx < IDX_W'(N_ENTRIES))) begin
      tree_row_d[wr_idx]  = wr_row;
      tree_col_d[wr_idx]  = wr_col;
      tree_data_d[wr_idx] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        tree_row_q[i]  <= DEFAULT_MATRIX[i].row;
        tree_col_q[i]  <= DEFAULT_MATRIX[i].col;
        tree_data_q[i] <= DEFAULT_MATRIX[i].data;
      end
    end else begin
      tree_row_q  <= tree_row_d;
      tree_col_q  <= tree_col_d;
      tree_data_q <= tree_data_d;
    end
  end

  coo_scanner u_scan (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .row_col_select (row_col_select),
    .row_col_number (row_col_number),
    .tree_row       (tree_row_q),
    .tree_col       (tree_col_q),
    .tree_data      (tree_data_q),
    .busy           (busy),
    .out_valid      (out_valid),
    .row            (row),
    .col            (col),
    .value          (value),
    .done           (done)
  );

endmodule

// File: tb/tb_sparse_matrix_tree.sv
module tb_sparse_matrix_tree;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_idx = '0;
  logic [15:0] wr_row = '0, wr_col = '0, wr_data = '0;
  logic        start = 1'b0;
  logic        row_col_select = 1'b0;
  logic [15:0] row_col_number = '0;
  logic        busy, out_valid, done;
  logic [15:0] row, col, value;

  sparse_matrix_tree dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .start(start), .row_col_select(row_col_select),
    .row_col_number(row_col_number), .busy(busy), .out_valid(out_valid),
    .row(row), .col(col), .value(value), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          cyc;
    logic [15:0] r, c, d;
  } exp_t;
  exp_t q[$];

  int m_row[15], m_col[15], m_dat[15];
  int exp_done;
  bit done_pend = 0;

  task automatic load_default();
    int dr[15] = '{0,0,1,1,2,2,3,3,4,4,5,5,6,6,7};
    int dc[15] = '{0,2,1,3,0,2,1,3,0,4,1,5,2,6,7};
    for (int i = 0; i < 15; i++) begin
      m_row[i] = dr[i]; m_col[i] = dc[i]; m_dat[i] = i + 1;
    end
  endtask

  task automatic chk(input string nm, input int got, input int expv);
    tests++;
    if (got != expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, got, expv, cyc);
    end
  endtask

  task automatic mon();
    exp_t e;
    if (out_valid) begin
      if (q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_out_valid: got (%0d,%0d,%0d) at cycle %0d, expected none",
                 row, col, value, cyc);
      end else begin
        e = q.pop_front();
        chk("ov_cycle", cyc, e.cyc);
        chk("ov_row", int'(row), int'(e.r));
        chk("ov_col", int'(col), int'(e.c));
        chk("ov_value", int'(value), int'(e.d));
      end
    end
    if (done) begin
      tests++;
      if (!done_pend || cyc != exp_done) begin
        fails++;
        $display("FAIL done_cycle: got done at cycle %0d, expected %0d (pending=%0d)",
                 cyc, exp_done, done_pend);
      end
      done_pend = 0;
      chk("busy_at_done", int'(busy), 0);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
  endtask

  // Offsets are relative to the negedge where start is raised (cycle s):
  // start edge is edge s+1, slot k appears at s+2+k, done at s+17.
  task automatic run_scan(input string nm, input logic sel, input int num,
                          input logic [14:0] mask, input int wr_off,
                          input int widx, input int wr_r, input int wr_c,
                          input int wr_d, input int xs_off, input int rst_off);
    int s;
    tick();
    s = cyc;
    for (int k = 0; k < 15; k++)
      if (mask[k]) q.push_back('{s + 2 + k, 16'(m_row[k]), 16'(m_col[k]), 16'(m_dat[k])});
    exp_done = s + 17;
    done_pend = 1;
    start = 1'b1; row_col_select = sel; row_col_number = 16'(num);
    for (int t = 1; t <= 40 && done_pend; t++) begin
      tick();
      if (t == 1) chk({nm, "_busy"}, int'(busy), 1);
      // mid-scan input wiggles must not disturb the latched request
      row_col_select = ~sel;
      row_col_number = 16'(num + 1);
      start  = (xs_off >= 0 && cyc == s + xs_off);
      wr_en  = (wr_off >= 0 && cyc == s + wr_off);
      wr_idx = 4'(widx); wr_row = 16'(wr_r); wr_col = 16'(wr_c); wr_data = 16'(wr_d);
      if (rst_off >= 0 && cyc == s + rst_off) begin
        rst = 1'b0;
        #1;
        chk({nm, "_rst_ov"}, int'(out_valid), 0);
        chk({nm, "_rst_row"}, int'(row), 0);
        chk({nm, "_rst_value"}, int'(value), 0);
        chk({nm, "_rst_busy"}, int'(busy), 0);
        q.delete();
        done_pend = 0;
        load_default();
        start = 1'b0; wr_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end
    end
    start = 1'b0; wr_en = 1'b0;
    if (done_pend) begin
      tests++; fails++;
      $display("FAIL %s_timeout: got no done, expected done at cycle %0d", nm, exp_done);
      done_pend = 0;
    end
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL %s_missing: got %0d entries unreturned, expected 0", nm, q.size());
      q.delete();
    end
  endtask

  typedef struct {
    string       name;
    logic        sel;
    int          num;
    logic [14:0] mask;   // slots expected to match, in default storage
  } vec_t;

  initial begin
    vec_t vecs[8];
    vecs[0] = '{"row1", 1'b0, 1, 15'h000C};
    vecs[1] = '{"col0", 1'b1, 0, 15'h0111};
    vecs[2] = '{"row9", 1'b0, 9, 15'h0000};
    vecs[3] = '{"col2", 1'b1, 2, 15'h1022};
    vecs[4] = '{"row7", 1'b0, 7, 15'h4000};
    vecs[5] = '{"col4", 1'b1, 4, 15'h0200};
    vecs[6] = '{"row0", 1'b0, 0, 15'h0003};
    vecs[7] = '{"col1", 1'b1, 1, 15'h0444};
    load_default();

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_row", int'(row), 0);
    chk("rst_col", int'(col), 0);
    chk("rst_value", int'(value), 0);
    rst = 1'b1;
    repeat (2) tick();

    foreach (vecs[i])
      run_scan(vecs[i].name, vecs[i].sel, vecs[i].num, vecs[i].mask, -1, 0, 0, 0, 0, -1, -1);

    // write to slot 5 in its own compare cycle: old contents are matched
    run_scan("samecyc", 1'b0, 2, 15'h0030, 6, 5, 3, 3, 77, -1, -1);
    m_row[5] = 3; m_col[5] = 3; m_dat[5] = 77;
    run_scan("row3_new", 1'b0, 3, 15'h00E0, -1, 0, 0, 0, 0, -1, -1);

    // slot 14 rewritten mid-scan before it is reached
    m_row[14] = 1; m_col[14] = 9; m_dat[14] = 99;
    run_scan("wr14", 1'b0, 1, 15'h400C, 4, 14, 1, 9, 99, -1, -1);

    // wr_idx=15 is dropped
    tick(); wr_en = 1'b1; wr_idx = 4'd15; wr_row = 16'd1; wr_col = 16'd9; wr_data = 16'd55;
    tick(); wr_en = 1'b0;
    run_scan("idx15_row1", 1'b0, 1, 15'h400C, -1, 0, 0, 0, 0, -1, -1);
    run_scan("idx15_col9", 1'b1, 9, 15'h4000, -1, 0, 0, 0, 0, -1, -1);

    // start raised in the DONE cycle is ignored
    run_scan("donestart", 1'b0, 0, 15'h0003, -1, 0, 0, 0, 0, 16, -1);

    // reset at scan cycle 5 of a column-0 scan
    run_scan("midrst", 1'b1, 0, 15'h0111, -1, 0, 0, 0, 0, -1, 6);
    run_scan("after_rst", 1'b1, 0, 15'h0111, -1, 0, 0, 0, 0, 5, -1);
    run_scan("row3_dflt", 1'b0, 3, 15'h00C0, -1, 0, 0, 0, 0, -1, -1);
    run_scan("row7_dflt", 1'b0, 7, 15'h4000, -1, 0, 0, 0, 0, -1, -1);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
